// File: rtl/axi_lite_mult_master.sv
// AXI-Lite master for the memory-mapped multiplier slave.
// For each start it writes operand A, then operand B, reads the result low word,
// then reads the overflow flag, and returns both with a one-cycle done pulse.
// Every bus state has its own watchdog, so a stuck slave cannot hang the master.
module axi_lite_mult_master #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned ADDR_A         = 0,
  parameter int unsigned ADDR_B         = 4,
  parameter int unsigned ADDR_RES       = 8,
  parameter int unsigned ADDR_OVF       = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    m1_axi_aclk,
  input  logic                    m1_axi_areset,
  // Local command / status port
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   op_a,
  input  logic [DATA_WIDTH-1:0]   op_b,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   result,
  output logic                    overflow,
  output logic                    err,
  output logic                    timeout,
  // AXI-Lite write channels
  output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
  output logic                    m1_axi_awvalid,
  input  logic                    m1_axi_awready,
  output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
  output logic                    m1_axi_wvalid,
  input  logic                    m1_axi_wready,
  input  logic                    m1_axi_bresp,
  input  logic                    m1_axi_bvalid,
  output logic                    m1_axi_bready,
  // AXI-Lite read channels
  output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
  output logic                    m1_axi_arvalid,
  input  logic                    m1_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
  input  logic                    m1_axi_rresp,
  input  logic                    m1_axi_rvalid,
  output logic                    m1_axi_rready
);

  localparam logic [ADDR_WIDTH-1:0] AddrA   = ADDR_WIDTH'(ADDR_A);
  localparam logic [ADDR_WIDTH-1:0] AddrB   = ADDR_WIDTH'(ADDR_B);
  localparam logic [ADDR_WIDTH-1:0] AddrRes = ADDR_WIDTH'(ADDR_RES);
  localparam logic [ADDR_WIDTH-1:0] AddrOvf = ADDR_WIDTH'(ADDR_OVF);
  // The counter starts at 0 on state entry, so this value is the last cycle allowed.
  localparam logic [7:0]            CntLast = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWrA,
    StWrB,
    StRdRes,
    StRdOvf,
    StFin
  } state_e;

  state_e state_q, state_d;

  logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic [ADDR_WIDTH-1:0] awaddr_q, araddr_q;
  logic [DATA_WIDTH-1:0] wdata_q, op_b_q, result_q;
  logic                  aw_done_q, w_done_q, ar_done_q;
  logic [7:0]            cnt_q;
  logic                  overflow_q, err_q, timeout_q;

  logic in_wr, in_rd, aw_ok, w_ok, b_hit, ar_ok, r_hit, expired;

  // A channel counts as complete if it finished earlier or completes this cycle,
  // which lets B (or R) be accepted in the same cycle as the last address/data handshake.
  always_comb begin
    in_wr   = (state_q == StWrA) || (state_q == StWrB);
    in_rd   = (state_q == StRdRes) || (state_q == StRdOvf);
    aw_ok   = aw_done_q || (awvalid_q && m1_axi_awready);
    w_ok    = w_done_q || (wvalid_q && m1_axi_wready);
    b_hit   = in_wr && bready_q && m1_axi_bvalid && aw_ok && w_ok;
    ar_ok   = ar_done_q || (arvalid_q && m1_axi_arready);
    r_hit   = in_rd && rready_q && m1_axi_rvalid && ar_ok;
    expired = (in_wr || in_rd) && (cnt_q == CntLast) && !b_hit && !r_hit;
  end

  // State register
  always_ff @(posedge m1_axi_aclk or posedge m1_axi_areset) begin
    if (m1_axi_areset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: advance on each completed access, or bail out to FIN on timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StWrA;
      StWrA:   if (expired) state_d = StFin; else if (b_hit) state_d = StWrB;
      StWrB:   if (expired) state_d = StFin; else if (b_hit) state_d = StRdRes;
      StRdRes: if (expired) state_d = StFin; else if (r_hit) state_d = StRdOvf;
      StRdOvf: if (expired) state_d = StFin; else if (r_hit) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs decoded from the state
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StFin);
  end

  // Bus channel registers, per-state watchdog and captured results
  always_ff @(posedge m1_axi_aclk or posedge m1_axi_areset) begin
    if (m1_axi_areset) begin
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awaddr_q   <= '0;
      araddr_q   <= '0;
      wdata_q    <= '0;
      op_b_q     <= '0;
      result_q   <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      ar_done_q  <= 1'b0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      if (in_wr || in_rd) begin
        cnt_q <= cnt_q + 8'd1;
      end

      // Each valid drops once its own handshake is done and stays low for the state
      if (awvalid_q && m1_axi_awready) begin
        awvalid_q <= 1'b0;
        aw_done_q <= 1'b1;
      end
      if (wvalid_q && m1_axi_wready) begin
        wvalid_q <= 1'b0;
        w_done_q <= 1'b1;
      end
      if (arvalid_q && m1_axi_arready) begin
        arvalid_q <= 1'b0;
        ar_done_q <= 1'b1;
      end

      if (b_hit && !m1_axi_bresp) begin
        err_q <= 1'b1;
      end
      if (r_hit) begin
        if (state_q == StRdRes) result_q <= m1_axi_rdata;
        if (state_q == StRdOvf) overflow_q <= m1_axi_rdata[0];
        if (!m1_axi_rresp) err_q <= 1'b1;
      end
      if (expired) begin
        timeout_q <= 1'b1;
        err_q     <= 1'b1;
      end

      if ((state_q == StIdle) && start) begin
        op_b_q     <= op_b;
        result_q   <= '0;
        overflow_q <= 1'b0;
        err_q      <= 1'b0;
        timeout_q  <= 1'b0;
      end

      // State entry overrides the per-cycle updates above
      if (state_d != state_q) begin
        cnt_q     <= '0;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        ar_done_q <= 1'b0;
        awvalid_q <= 1'b0;
        wvalid_q  <= 1'b0;
        bready_q  <= 1'b0;
        arvalid_q <= 1'b0;
        rready_q  <= 1'b0;
        case (state_d)
          StWrA: begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            bready_q  <= 1'b1;
            awaddr_q  <= AddrA;
            wdata_q   <= op_a;
          end
          StWrB: begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            bready_q  <= 1'b1;
            awaddr_q  <= AddrB;
            wdata_q   <= op_b_q;
          end
          StRdRes: begin
            arvalid_q <= 1'b1;
            rready_q  <= 1'b1;
            araddr_q  <= AddrRes;
          end
          StRdOvf: begin
            arvalid_q <= 1'b1;
            rready_q  <= 1'b1;
            araddr_q  <= AddrOvf;
          end
          default: ;
        endcase
      end
    end
  end

  assign m1_axi_awaddr  = awaddr_q;
  assign m1_axi_awvalid = awvalid_q;
  assign m1_axi_wdata   = wdata_q;
  assign m1_axi_wstrb   = '1;
  assign m1_axi_wvalid  = wvalid_q;
  assign m1_axi_bready  = bready_q;
  assign m1_axi_araddr  = araddr_q;
  assign m1_axi_arvalid = arvalid_q;
  assign m1_axi_rready  = rready_q;
  assign result         = result_q;
  assign overflow       = overflow_q;
  assign err            = err_q;
  assign timeout        = timeout_q;

endmodule

// File: tb/tb_axi_lite_mult_master.sv
// Scoreboard bench for axi_lite_mult_master with a configurable multiplier slave model.
// Stimulus pushes the expected bus accesses and completion values into queues;
// monitors pop and compare whenever the DUT presents a handshake or a done pulse.
module tb_axi_lite_mult_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        busy, done, overflow, err, timeout;
  logic [31:0] result;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bresp, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic        arvalid, arready, rresp, rvalid, rready;

  always #5 clk = ~clk;

  axi_lite_mult_master dut (
    .m1_axi_aclk    (clk),
    .m1_axi_areset  (rst),
    .start          (start),
    .op_a           (op_a),
    .op_b           (op_b),
    .busy           (busy),
    .done           (done),
    .result         (result),
    .overflow       (overflow),
    .err            (err),
    .timeout        (timeout),
    .m1_axi_awaddr  (awaddr),
    .m1_axi_awvalid (awvalid),
    .m1_axi_awready (awready),
    .m1_axi_wdata   (wdata),
    .m1_axi_wstrb   (wstrb),
    .m1_axi_wvalid  (wvalid),
    .m1_axi_wready  (wready),
    .m1_axi_bresp   (bresp),
    .m1_axi_bvalid  (bvalid),
    .m1_axi_bready  (bready),
    .m1_axi_araddr  (araddr),
    .m1_axi_arvalid (arvalid),
    .m1_axi_arready (arready),
    .m1_axi_rdata   (rdata),
    .m1_axi_rresp   (rresp),
    .m1_axi_rvalid  (rvalid),
    .m1_axi_rready  (rready)
  );

  // ---------------- slave model ----------------
  int          aw_len    = 1;     // cycles awvalid stays high, handshake cycle included
  bit          early_b   = 1'b0;  // raise bvalid combinationally with the last AW/W handshake
  bit          bad_en    = 1'b0;
  logic [7:0]  bad_addr  = 8'd0;  // write address answered with bresp=0
  bit          stall_res = 1'b0;  // never accept AR for the result address

  logic [31:0] reg_a, reg_b, wd_q, rdata_q;
  logic [7:0]  wa_q;
  logic        got_aw, got_w, bvalid_q, rvalid_q;
  int          aw_wait;
  logic [63:0] prod;
  logic        aw_hs, w_hs, aw_have, w_have;
  logic [7:0]  cur_waddr;
  logic [31:0] cur_wdata;

  assign prod      = {32'd0, reg_a} * {32'd0, reg_b};
  assign awready   = awvalid && ((aw_wait + 1) >= aw_len);
  assign wready    = wvalid;
  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign aw_have   = got_aw || aw_hs;
  assign w_have    = got_w || w_hs;
  assign cur_waddr = got_aw ? wa_q : awaddr;
  assign cur_wdata = got_w ? wd_q : wdata;
  assign bvalid    = early_b ? (aw_have && w_have) : bvalid_q;
  assign bresp     = !(bad_en && (cur_waddr == bad_addr));
  assign arready   = arvalid && !(stall_res && (araddr == 8'd8));
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign rresp     = 1'b1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_a <= '0; reg_b <= '0; wd_q <= '0; wa_q <= '0; rdata_q <= '0;
      got_aw <= 1'b0; got_w <= 1'b0; bvalid_q <= 1'b0; rvalid_q <= 1'b0; aw_wait <= 0;
    end else begin
      if (awvalid && !awready) aw_wait <= aw_wait + 1;
      else aw_wait <= 0;
      if (aw_hs) begin got_aw <= 1'b1; wa_q <= awaddr; end
      if (w_hs) begin got_w <= 1'b1; wd_q <= wdata; end
      if (bvalid && bready) begin
        got_aw   <= 1'b0;
        got_w    <= 1'b0;
        bvalid_q <= 1'b0;
        if (cur_waddr == 8'd0) reg_a <= cur_wdata;
        if (cur_waddr == 8'd4) reg_b <= cur_wdata;
      end else if (!early_b && aw_have && w_have) begin
        bvalid_q <= 1'b1;
      end
      if (arvalid && arready) begin
        rvalid_q <= 1'b1;
        rdata_q  <= (araddr == 8'd8)  ? prod[31:0] :
                    (araddr == 8'd12) ? {31'd0, |prod[63:32]} : 32'd0;
      end else if (rvalid && rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        err;
    logic        to;
  } done_t;
  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  done_t      exp_done_q[$];
  wr_t        exp_wr_q[$];
  logic [7:0] exp_rd_q[$];
  done_t      de;
  wr_t        we;
  logic [7:0] re;

  int errors = 0, checks = 0;
  int done_seen = 0, aw_hi = 0, w_hi = 0, ar_hi = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic ovf, input logic e, input logic to,
                         input bit reads);
    exp_wr_q.push_back('{addr: 8'd0, data: a});
    exp_wr_q.push_back('{addr: 8'd4, data: b});
    if (reads) begin
      exp_rd_q.push_back(8'd8);
      exp_rd_q.push_back(8'd12);
    end
    exp_done_q.push_back('{res: res, ovf: ovf, err: e, to: to});
  endtask

  // Completion monitor
  always @(negedge clk) begin
    if (done) begin
      done_seen++;
      checks++;
      if (exp_done_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got done=1 required no pending operation");
      end else begin
        de = exp_done_q.pop_front();
        check("result", 64'(result), 64'(de.res));
        check("overflow", 64'(overflow), 64'(de.ovf));
        check("err", 64'(err), 64'(de.err));
        check("timeout", 64'(timeout), 64'(de.to));
      end
    end
  end

  // Bus monitor: each write is checked on its B handshake, each read on its AR handshake
  always @(negedge clk) begin
    if (awvalid) aw_hi++;
    if (wvalid) w_hi++;
    if (arvalid) ar_hi++;
    if (!rst && bvalid && bready) begin
      checks++;
      if (exp_wr_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got addr=%0d data=0x%0h required none", cur_waddr,
                 cur_wdata);
      end else begin
        we = exp_wr_q.pop_front();
        check("write_addr", 64'(cur_waddr), 64'(we.addr));
        check("write_data", 64'(cur_wdata), 64'(we.data));
      end
    end
    if (!rst && arvalid && arready) begin
      checks++;
      if (exp_rd_q.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected: got addr=%0d required none", araddr);
      end else begin
        re = exp_rd_q.pop_front();
        check("read_addr", 64'(araddr), 64'(re));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL %s_wait: got no done within %0d cycles required done", name, budget);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    #12;
    // Outputs while reset is held
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    check("rst_addr", 64'({awaddr, araddr}), 64'd0);
    check("rst_status", 64'({result, overflow, err, timeout}), 64'd0);
    check("wstrb", 64'(wstrb), 64'hf);
    @(negedge clk);
    rst = 1'b0;

    // 6*7 with a zero-wait slave; a second start while busy must be ignored.
    // Latency counts clock edges from raising start (just after an edge) to done visible.
    push_op(32'd6, 32'd7, 32'd42, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    op_a = 32'd6; op_b = 32'd7; start = 1'b1;
    n = 0;
    while (!done && n < 50) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) start = 1'b0;
      if (n == 3) start = 1'b1;
      if (n == 4) start = 1'b0;
    end
    check("t1_latency", 64'(n), 64'd9);
    repeat (20) @(posedge clk);
    #1;
    check("t1_idle_busy", 64'(busy), 64'd0);
    check("t1_one_op", 64'(done_seen), 64'd1);

    // Product overflows the low word
    push_op(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    start_op(32'h0001_0000, 32'h0001_0000);
    wait_done("t2", 100);

    // Slow AW, immediate W, B raised with the AW handshake
    aw_len = 3; early_b = 1'b1;
    push_op(32'd2, 32'd3, 32'd6, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    aw_hi = 0; w_hi = 0;
    start_op(32'd2, 32'd3);
    wait_done("t3", 100);
    check("t3_awvalid_cycles", 64'(aw_hi), 64'd6);
    check("t3_wvalid_cycles", 64'(w_hi), 64'd2);
    aw_len = 1; early_b = 1'b0;

    // Error response on the operand-B write; both reads still happen
    bad_en = 1'b1; bad_addr = 8'd4;
    push_op(32'd5, 32'd9, 32'd45, 1'b0, 1'b1, 1'b0, 1'b1);
    start_op(32'd5, 32'd9);
    wait_done("t4", 100);
    bad_en = 1'b0;

    // AR never accepted for the result: timeout after 255 cycles, no read of addr 12
    stall_res = 1'b1;
    push_op(32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    ar_hi = 0;
    start_op(32'd1, 32'd1);
    wait_done("t5", 1000);
    check("t5_arvalid_cycles", 64'(ar_hi), 64'd255);
    stall_res = 1'b0;

    // Reset in WR_B while awvalid is high, then a clean operation
    aw_len = 5;
    exp_wr_q.push_back('{addr: 8'd0, data: 32'd3});
    start_op(32'd3, 32'd5);
    n = 0;
    while (!(awvalid && awaddr == 8'd4) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_wrb", 64'(awvalid && awaddr == 8'd4), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_valids", 64'({awvalid, wvalid, bready}), 64'd0);
    check("t6_async_busy", 64'(busy), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    aw_len = 1;
    push_op(32'd3, 32'd5, 32'd15, 1'b0, 1'b0, 1'b0, 1'b1);
    start_op(32'd3, 32'd5);
    wait_done("t6", 100);

    repeat (5) @(posedge clk);
    #1;
    check("pending_done", 64'(exp_done_q.size()), 64'd0);
    check("pending_writes", 64'(exp_wr_q.size()), 64'd0);
    check("pending_reads", 64'(exp_rd_q.size()), 64'd0);
    check("done_total", 64'(done_seen), 64'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000 required finish");
    $fatal(1);
  end

endmodule
